// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx: serial UART transmitter.
// Sends one frame per accepted word: a start bit (0), data_width data bits
// LSB first, an optional even-parity bit, and one stop bit (1).
// The bit period is set at runtime by CLKS_PER_BIT. The value is latched when a
// frame is accepted, and a latched 0 is treated as 1.
//
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit follows the data bits and a frame is 11N long. Otherwise a frame is 10N.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   CLKS_PER_BIT clock cycles per serial bit, sampled on acceptance
//   start        level-sensitive send request
//   data_in      word to transmit, sampled on acceptance
//   tx           registered serial line, idles high
//   busy         high while a frame is in progress, including the DONE cycle
//   done         one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [12:0]           CLKS_PER_BIT,
  input  logic                  start,
  input  logic [data_width-1:0] data_in,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W = 13;
  localparam int unsigned BIT_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(data_width - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;
`endif

  state_t                state_q;
  logic [CNT_W-1:0]      clk_cnt_q;
  logic [CNT_W-1:0]      period_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [data_width-1:0] shift_q;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  // Final clock of the current bit period.
  logic bit_end;
  assign bit_end = (clk_cnt_q == (period_q - CNT_W'(1)));

  // Frame sequencer with registered tx/busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      period_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        // The DONE cycle also acts as the acceptance edge so a held start
        // yields exactly N+1 high cycles (stop bit + DONE) between frames.
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state_q   <= S_START;
            clk_cnt_q <= '0;
            period_q  <= (CLKS_PER_BIT == '0) ? CNT_W'(1) : CLKS_PER_BIT;
            bit_cnt_q <= '0;
            shift_q   <= data_in;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^data_in;
`endif
            tx        <= 1'b0;
            busy      <= 1'b1;
          end else begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
          end
        end

        S_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_DATA;
            tx        <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx      <= parity_q;
`else
              state_q <= S_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              tx        <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_STOP;
            tx        <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            clk_cnt_q <= '0;
            state_q   <= S_DONE;
            done      <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end

        // Recover from illegal encodings to a quiet line.
        default: begin
          state_q   <= S_IDLE;
          clk_cnt_q <= '0;
          tx        <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx: directed self-checking bench for uart_tx.
// Outputs are sampled 1 time unit after each rising edge. Sample k is the value
// after acceptance edge k. The optional parity scenario is compiled only when
// UART_TX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [12:0] clks_per_bit;
  logic        start;
  logic [7:0]  data_in;
  logic        tx;
  logic        busy;
  logic        done;

  int total;
  int bad;

  uart_tx #(.data_width(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .CLKS_PER_BIT (clks_per_bit),
    .start        (start),
    .data_in      (data_in),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference line model for a single frame accepted at k=0 with period n.
  function automatic logic exp_tx(input int k, input logic [7:0] d, input int n);
    int idx;
    if (k < n) return 1'b0;
    idx = k / n - 1;
    if (idx < 8) return d[idx];
    if (PAR_EN && idx == 8) return ^d;
    return 1'b1;
  endfunction

  function automatic int frame_len(input int n);
    return PAR_EN ? 11 * n : 10 * n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset state and a quiet line for 100 cycles with start low.
  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    data_in = 8'h00;
    clks_per_bit = 13'd16;
    tick();
    tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet k=%0d tx=%b busy=%b done=%b want 1 0 0", k, tx, busy, done);
      end
    end
  endtask

  // N=16, 0xA5, one-cycle start pulse.
  task automatic test_basic();
    int fl;
    fl = frame_len(16);
    @(negedge clk);
    clks_per_bit = 13'd16;
    data_in = 8'hA5;
    start = 1'b1;
    for (int k = 0; k <= fl + 4; k++) begin
      tick();
      if (k == 0) start = 1'b0;
      total++;
      if (tx !== exp_tx(k, 8'hA5, 16)) begin
        bad++;
        $display("FAIL basic_tx k=%0d tx=%b want %b", k, tx, exp_tx(k, 8'hA5, 16));
      end
      total++;
      if (done !== (k == fl)) begin
        bad++;
        $display("FAIL basic_done k=%0d done=%b want %b", k, done, (k == fl));
      end
      total++;
      if (busy !== (k <= fl)) begin
        bad++;
        $display("FAIL basic_busy k=%0d busy=%b want %b", k, busy, (k <= fl));
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  // N=4 even parity for an odd-weight and an even-weight word.
  task automatic test_parity();
    logic [7:0] words [2];
    words[0] = 8'h07;
    words[1] = 8'h03;
    for (int w = 0; w < 2; w++) begin
      idle_cycles(3);
      @(negedge clk);
      clks_per_bit = 13'd4;
      data_in = words[w];
      start = 1'b1;
      for (int k = 0; k <= 46; k++) begin
        tick();
        if (k == 0) start = 1'b0;
        total++;
        if (tx !== exp_tx(k, words[w], 4)) begin
          bad++;
          $display("FAIL parity_tx w=%0d k=%0d tx=%b want %b", w, k, tx, exp_tx(k, words[w], 4));
        end
        total++;
        if (done !== (k == 44)) begin
          bad++;
          $display("FAIL parity_done w=%0d k=%0d done=%b want %b", w, k, done, (k == 44));
        end
      end
    end
  endtask
`endif

  // N=8, start held: 0x55 then 0x0F, with inputs disturbed mid-frame.
  task automatic test_back_to_back();
    int fl;
    int k2;
    logic e_tx;
    fl = frame_len(8);
    idle_cycles(3);
    @(negedge clk);
    clks_per_bit = 13'd8;
    data_in = 8'h55;
    start = 1'b1;
    for (int k = 0; k <= 2 * fl + 3; k++) begin
      tick();
      if (k == 0) begin
        data_in = 8'h0F;
        clks_per_bit = 13'd3;
      end
      if (k == fl - 10) clks_per_bit = 13'd8;
      if (k == fl + 1) start = 1'b0;
      k2 = k - (fl + 1);
      e_tx = (k <= fl) ? exp_tx(k, 8'h55, 8) : exp_tx(k2, 8'h0F, 8);
      total++;
      if (tx !== e_tx) begin
        bad++;
        $display("FAIL b2b_tx k=%0d tx=%b want %b", k, tx, e_tx);
      end
      total++;
      if (done !== (k == fl || k == 2 * fl + 1)) begin
        bad++;
        $display("FAIL b2b_done k=%0d done=%b want %b", k, done, (k == fl || k == 2 * fl + 1));
      end
      total++;
      if (busy !== (k <= 2 * fl + 1)) begin
        bad++;
        $display("FAIL b2b_busy k=%0d busy=%b want %b", k, busy, (k <= 2 * fl + 1));
      end
    end
  endtask

  // Async reset mid data bit, then a clean 0x3C frame.
  task automatic test_reset_mid();
    int fl;
    fl = frame_len(16);
    idle_cycles(3);
    @(negedge clk);
    clks_per_bit = 13'd16;
    data_in = 8'h5A;
    start = 1'b1;
    for (int k = 0; k <= 50; k++) begin
      tick();
      if (k == 0) start = 1'b0;
    end
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort tx=%b busy=%b want 0 1", tx, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_abort tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick();
      total++;
      if (done !== 1'b0 || tx !== 1'b1) begin
        bad++;
        $display("FAIL abort_quiet k=%0d done=%b tx=%b want 0 1", k, done, tx);
      end
    end
    @(negedge clk);
    data_in = 8'h3C;
    start = 1'b1;
    for (int k = 0; k <= fl + 2; k++) begin
      tick();
      if (k == 0) start = 1'b0;
      total++;
      if (tx !== exp_tx(k, 8'h3C, 16)) begin
        bad++;
        $display("FAIL post_reset_tx k=%0d tx=%b want %b", k, tx, exp_tx(k, 8'h3C, 16));
      end
      total++;
      if (done !== (k == fl)) begin
        bad++;
        $display("FAIL post_reset_done k=%0d done=%b want %b", k, done, (k == fl));
      end
    end
  endtask

  // CLKS_PER_BIT=0 behaves as 1-cycle bits.
  task automatic test_zero_period();
    int fl;
    fl = frame_len(1);
    idle_cycles(3);
    @(negedge clk);
    clks_per_bit = 13'd0;
    data_in = 8'hFF;
    start = 1'b1;
    for (int k = 0; k <= fl + 2; k++) begin
      tick();
      if (k == 0) start = 1'b0;
      total++;
      if (tx !== exp_tx(k, 8'hFF, 1)) begin
        bad++;
        $display("FAIL zero_tx k=%0d tx=%b want %b", k, tx, exp_tx(k, 8'hFF, 1));
      end
      total++;
      if (done !== (k == fl)) begin
        bad++;
        $display("FAIL zero_done k=%0d done=%b want %b", k, done, (k == fl));
      end
      total++;
      if (busy !== (k <= fl)) begin
        bad++;
        $display("FAIL zero_busy k=%0d busy=%b want %b", k, busy, (k <= fl));
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_mid();
    test_zero_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
